// File: rtl/osd_ram_writer.sv
// OSD bitmap writer: parses UDP payload packets into byte writes of the
// OSD bitmap RAM, and runs a full-RAM clear on command.
module osd_ram_writer #(
  parameter logic [7:0] MAGIC_WR  = 8'hA5,
  parameter logic [7:0] MAGIC_CLR = 8'h5A,
  parameter int         RAM_DEPTH = 2048,
  localparam int        AW        = $clog2(RAM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          udp_rec_sof,
  input  logic          udp_rec_data_valid,
  input  logic [7:0]    udp_rec_data,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [7:0]    ram_wr_data,
  output logic          osd_valid,
  output logic          busy,
  output logic          pkt_done,
  output logic          pkt_err
);

  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, OFS_H, OFS_L, LEN_H, LEN_L, PAYLOAD, CLEAR, DROP
  } state_t;

  state_t        state_q;
  state_t        hdr_d;
  logic [AW-1:0] ofs_q;
  logic [15:0]   cnt_q;
  logic [PW-1:0] ptr_q;
  logic          ovf_q;
  logic [AW-1:0] clr_q;
  logic          sof_ok;
  logic          byte_ok;
  logic          wr_ok;
  logic [15:0]   len_d;

  always_comb begin
    hdr_d = DROP;
    if (udp_rec_data == MAGIC_WR)
      hdr_d = OFS_H;
    else if (udp_rec_data == MAGIC_CLR)
      hdr_d = CLEAR;
  end

  assign byte_ok = udp_rec_data_valid;
  assign sof_ok  = udp_rec_data_valid & udp_rec_sof;
  assign len_d   = {cnt_q[15:8], udp_rec_data};
  // ovf_q is sticky so a wrapping pointer never re-enters the RAM
  assign wr_ok   = !ovf_q && (ptr_q < PW'(RAM_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ofs_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      ovf_q       <= 1'b0;
      clr_q       <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      osd_valid   <= 1'b0;
      busy        <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_err     <= 1'b0;
    end else begin
      ram_wr_en <= 1'b0;
      busy      <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      if (state_q == CLEAR) begin
        busy        <= 1'b1;
        ram_wr_en   <= 1'b1;
        ram_wr_addr <= clr_q;
        ram_wr_data <= 8'h00;
        clr_q       <= clr_q + AW'(1);
        if (clr_q == AW'(RAM_DEPTH - 1)) begin
          pkt_done <= 1'b1;
          state_q  <= IDLE;
        end
      end else if (sof_ok) begin
        if (state_q inside {OFS_H, OFS_L, LEN_H, LEN_L, PAYLOAD})
          pkt_err <= 1'b1;
        if (hdr_d != DROP)
          osd_valid <= 1'b0;
        clr_q   <= '0;
        state_q <= hdr_d;
      end else if (byte_ok) begin
        unique case (state_q)
          OFS_H: begin
            ofs_q   <= AW'({udp_rec_data, ofs_q[7:0]});
            state_q <= OFS_L;
          end
          OFS_L: begin
            ofs_q[7:0] <= udp_rec_data;
            state_q    <= LEN_H;
          end
          LEN_H: begin
            cnt_q[15:8] <= udp_rec_data;
            state_q     <= LEN_L;
          end
          LEN_L: begin
            cnt_q <= len_d;
            ptr_q <= {1'b0, ofs_q};
            ovf_q <= 1'b0;
            if (len_d == 16'd0) begin
              pkt_done  <= 1'b1;
              osd_valid <= 1'b1;
              state_q   <= IDLE;
            end else begin
              state_q <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (wr_ok) begin
              ram_wr_en   <= 1'b1;
              ram_wr_addr <= ptr_q[AW-1:0];
              ram_wr_data <= udp_rec_data;
            end else begin
              ovf_q <= 1'b1;
            end
            ptr_q <= ptr_q + PW'(1);
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              state_q <= IDLE;
              if (wr_ok) begin
                pkt_done  <= 1'b1;
                osd_valid <= 1'b1;
              end else begin
                pkt_err <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_osd_ram_writer.sv
// Scoreboard bench for osd_ram_writer: driver queues expected writes and
// completion pulses, a negedge monitor pops and compares them.
module tb_osd_ram_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sof = 1'b0;
  logic        vld = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        ram_wr_en;
  logic [10:0] ram_wr_addr;
  logic [7:0]  ram_wr_data;
  logic        osd_valid;
  logic        busy;
  logic        pkt_done;
  logic        pkt_err;

  osd_ram_writer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .udp_rec_sof        (sof),
    .udp_rec_data_valid (vld),
    .udp_rec_data       (din),
    .ram_wr_en          (ram_wr_en),
    .ram_wr_addr        (ram_wr_addr),
    .ram_wr_data        (ram_wr_data),
    .osd_valid          (osd_valid),
    .busy               (busy),
    .pkt_done           (pkt_done),
    .pkt_err            (pkt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  typedef struct {
    logic err;
    int   c;
  } ev_t;

  wr_t        wq[$];
  ev_t        eq[$];
  logic [7:0] pl[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         busy_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    wr_t w;
    ev_t e;
    if (busy) busy_cnt++;
    if (ram_wr_en) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none",
                 ram_wr_addr, ram_wr_data);
      end else begin
        w = wq.pop_front();
        if (ram_wr_addr !== w.a || ram_wr_data !== w.d || cyc != w.c) begin
          failures++;
          $display("FAIL write actual=%0h:%0h@%0d required=%0h:%0h@%0d",
                   ram_wr_addr, ram_wr_data, cyc, w.a, w.d, w.c);
        end
      end
    end
    if (pkt_done || pkt_err) begin
      checks++;
      if (eq.size() == 0 || (pkt_done && pkt_err)) begin
        failures++;
        $display("FAIL unexpected_pulse actual=done%0b/err%0b required=none",
                 pkt_done, pkt_err);
        if (eq.size() != 0) void'(eq.pop_front());
      end else begin
        e = eq.pop_front();
        if (pkt_err !== e.err || cyc != e.c) begin
          failures++;
          $display("FAIL pulse actual=err%0b@%0d required=err%0b@%0d",
                   pkt_err, cyc, e.err, e.c);
        end
      end
    end
  end

  task automatic put(input logic s, input logic [7:0] d, output int c);
    @(negedge clk);
    sof = s;
    vld = 1'b1;
    din = d;
    c   = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sof = 1'b0;
      vld = 1'b0;
      din = 8'h00;
    end
  endtask

  task automatic wr_pkt(input logic [15:0] ofs, input logic [15:0] len,
                        input int nsend, input int gap, input bit abort_prev);
    int c;
    int ptr;
    bit bad;
    put(1'b1, 8'hA5, c);
    if (abort_prev) eq.push_back(ev_t'{1'b1, c + 1});
    idle(gap);
    put(1'b0, ofs[15:8], c); idle(gap);
    put(1'b0, ofs[7:0], c);  idle(gap);
    put(1'b0, len[15:8], c); idle(gap);
    put(1'b0, len[7:0], c);  idle(gap);
    if (len == 16'd0) eq.push_back(ev_t'{1'b0, c + 1});
    ptr = int'(ofs[10:0]);
    bad = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      put(1'b0, pl[i], c);
      if (ptr < 2048) wq.push_back(wr_t'{ptr[10:0], pl[i], c + 1});
      else bad = 1'b1;
      ptr++;
      if (i == int'(len) - 1) eq.push_back(ev_t'{bad, c + 1});
      idle(gap);
    end
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((wq.size() != 0 || eq.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    idle(2);
    chk(nm, wq.size() + eq.size(), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_wr_en"}, ram_wr_en, 0);
    chk({nm, "_addr"}, ram_wr_addr, 0);
    chk({nm, "_data"}, ram_wr_data, 0);
    chk({nm, "_osd"}, osd_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, pkt_done, 0);
    chk({nm, "_err"}, pkt_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // sof without valid, then non-sof bytes in IDLE: all ignored
    @(negedge clk);
    sof = 1'b1; vld = 1'b0; din = 8'hA5;
    put(1'b0, 8'h00, c); put(1'b0, 8'h10, c);
    put(1'b0, 8'h00, c); put(1'b0, 8'h01, c);
    put(1'b0, 8'h11, c);
    idle(4);
    chk("ignore_osd", osd_valid, 0);

    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr_pkt(16'h0010, 16'd4, 4, 0, 1'b0);
    idle(1);
    drain("basic_drain");
    chk("basic_osd", osd_valid, 1);

    wr_pkt(16'h0010, 16'd4, 4, 1, 1'b0);
    idle(1);
    drain("gap_drain");
    chk("gap_osd", osd_valid, 1);

    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wr_pkt(16'h07FE, 16'd4, 4, 0, 1'b0);
    idle(1);
    drain("ovf_drain");
    chk("ovf_osd", osd_valid, 0);

    wr_pkt(16'h0123, 16'd0, 0, 0, 1'b0);
    idle(1);
    drain("len0_drain");
    chk("len0_osd", osd_valid, 1);

    pl = '{8'h01, 8'h02, 8'h03};
    wr_pkt(16'h0000, 16'd8, 3, 0, 1'b0);
    pl = '{8'h55, 8'h66};
    wr_pkt(16'h0100, 16'd2, 2, 0, 1'b1);
    idle(1);
    drain("abort_drain");
    chk("abort_osd", osd_valid, 1);

    put(1'b1, 8'h77, c);
    put(1'b0, 8'hA5, c); put(1'b0, 8'h5A, c); put(1'b0, 8'h12, c);
    pl = '{8'h9A};
    wr_pkt(16'h07FF, 16'd1, 1, 0, 1'b0);
    idle(1);
    drain("drop_drain");
    chk("drop_osd", osd_valid, 1);

    busy_cnt = 0;
    put(1'b1, 8'h5A, c);
    for (int i = 0; i < 2048; i++)
      wq.push_back(wr_t'{i[10:0], 8'h00, c + 2 + i});
    eq.push_back(ev_t'{1'b0, c + 2049});
    for (int i = 0; i < 100; i++)
      put(i % 25 == 3, (i % 2 == 0) ? 8'hA5 : i[7:0], c);
    idle(1);
    drain("clear_drain");
    chk("clear_busy_cycles", busy_cnt, 2048);
    chk("clear_osd", osd_valid, 0);

    put(1'b1, 8'h77, c);
    put(1'b0, 8'h11, c); put(1'b0, 8'h22, c);
    put(1'b1, 8'h5A, c);
    for (int i = 0; i < 49; i++)
      wq.push_back(wr_t'{i[10:0], 8'h00, c + 2 + i});
    repeat (50) begin
      @(negedge clk);
      sof = 1'b0; vld = 1'b0; din = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("midclr_rst");
    rst_n = 1'b1;
    idle(2100);
    chk("midclr_leftover", wq.size() + eq.size(), 0);
    chk_zero("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
